// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state type, word macros and constants for instruction fetch
`ifndef WORD
`define WORD 63:0
`endif
`ifndef CYCLE
`define CYCLE 10
`endif
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_sequencer_reg.sv
// fetch_sequencer_reg: enabled register with asynchronous reset value
module fetch_sequencer_reg #(
  parameter int W = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner issuing one imem read at a time and buffering the result for decode
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [`WORD]       imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [`WORD]       if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               br_taken,
  input  logic [`WORD]       br_target
);
  fetch_state_t state;
  logic squash, pc_en;
  logic [`WORD] pc, pc_d;
  assign pc_en = (br_taken && state != S_IDLE) || (state == S_WAIT && imem_resp_valid && !squash);
  assign pc_d = br_taken ? (br_target & ~64'h3) : pc + 64'(INSTR_BYTES);
  assign imem_addr = pc;
  fetch_sequencer_reg #(.W(64), .RST_VAL(RESET_PC)) u_pc (
    .clk, .reset, .en(pc_en), .d(pc_d), .q(pc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      squash <= 1'b0;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
      imem_req_valid <= 1'b0;
    end else
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          imem_req_valid <= 1'b1;
        end
        S_REQ: if (imem_req_ready) begin
          state <= S_WAIT;
          squash <= br_taken;
          imem_req_valid <= 1'b0;
        end
        S_WAIT: if (imem_resp_valid) begin
          if (!squash && !br_taken) begin
            if_pc <= pc;
            if_instr <= imem_resp_data;
            if_valid <= 1'b1;
            state <= S_OUT;
          end else begin
            imem_req_valid <= 1'b1;
            state <= S_REQ;
          end
          squash <= 1'b0;
        end else if (br_taken) squash <= 1'b1;
        S_OUT: if (br_taken || if_ready) begin
          state <= S_REQ;
          if_valid <= 1'b0;
          imem_req_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
endmodule
